// File: rtl/n_adder_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// Holds the FSM state encoding and the slice-index width calculation.
package n_adder_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} seq_state_t;

   // A single-slice sequencer still needs a one-bit index register.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/n_adder.sv
// N-bit ripple adder slice with carry in and carry out.
// This is the only arithmetic in the sequencer datapath.
module n_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] s,
   output logic         c_out
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/n_adder_seq_ctrl.sv
// Multi-precision add sequencer: adds W = N*WORDS-bit operands one N-bit slice per
// clock through a single n_adder, LSB slice first, with the carry held in a register.
module n_adder_seq_ctrl
   import n_adder_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a_in,
   input  logic [N*WORDS-1:0]   b_in,
   input  logic                 c_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 c_out,
   output logic                 overflow
);

   localparam int W  = N * WORDS;
   localparam int IW = idx_width(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   seq_state_t      state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            c_out_q, c_out_d;
   logic            ovf_q, ovf_d;

   logic [N-1:0]    a_slice, b_slice, add_s;
   logic            add_c;

   n_adder #(.N(N)) u_add (
      .a     (a_slice),
      .b     (b_slice),
      .c_in  (carry_q),
      .s     (add_s),
      .c_out (add_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == IW'(i)) begin
            a_slice = a_q[i*N +: N];
            b_slice = b_q[i*N +: N];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = c_in;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[i*N +: N] = add_s;
               end
            end
            carry_d = add_c;
            idx_d   = idx_q + IW'(1);
            // Signed overflow only depends on the operand signs and the top result bit.
            if (idx_q == LAST_IDX) begin
               c_out_d = add_c;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[N-1] != a_q[W-1]);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      sum       = sum_q;
      c_out     = c_out_q;
      overflow  = ovf_q;
   end

endmodule

// File: tb/tb_n_adder_seq_ctrl.sv
// Self-checking bench for n_adder_seq_ctrl (N=8, WORDS=4): directed vector table,
// back-pressure and mid-run reset sequences, then randomized ops against an adder model.
module tb_n_adder_seq_ctrl;

   localparam int N     = 8;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;

   int total  = 0;
   int passed = 0;

   typedef struct {
      string        name;
      logic [31:0]  a;
      logic [31:0]  b;
      logic         ci;
      logic [31:0]  es;
      logic         ec;
      logic         eo;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   n_adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow)
   );

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, presents one operand for a single accept edge, then counts cycles to out_valid.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                input bit rnd_ready, output int lat);
      int g;
      g = 0;
      while (!in_ready && g < 20) begin
         tick();
         g++;
      end
      checkOutput("in_ready before accept", {31'b0, in_ready}, 32'd1);
      a_in     = a;
      b_in     = b;
      c_in     = ci;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checkOutput("in_ready during RUN", {31'b0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
   endtask

   initial begin
      int          lat;
      int          seen;
      int          g;
      logic [31:0] ra, rb, es;
      logic        rc, ec, eo;

      vecs[0] = '{"ff_plus_1",      32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[1] = '{"all_ones_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{"pos_overflow",   32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{"neg_overflow",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[4] = '{"mixed",          32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
      vecs[5] = '{"max_with_cin",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[6] = '{"slice_carries",  32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      c_in      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset sum",       sum,                32'd0);
      checkOutput("reset c_out",     {31'b0, c_out},     32'd0);
      checkOutput("reset overflow",  {31'b0, overflow},  32'd0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, lat);
         checkOutput({vecs[i].name, " latency"},  lat, 32'd4);
         checkOutput({vecs[i].name, " sum"},      sum, vecs[i].es);
         checkOutput({vecs[i].name, " c_out"},    {31'b0, c_out},    {31'b0, vecs[i].ec});
         checkOutput({vecs[i].name, " overflow"}, {31'b0, overflow}, {31'b0, vecs[i].eo});
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         checkOutput({vecs[i].name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
      end

      // Back-pressure in DONE with a competing request that must not be accepted.
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
      a_in     = 32'hDEADBEEF;
      b_in     = 32'h01010101;
      c_in     = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("hold sum",       sum,                32'h23456789);
         checkOutput("hold in_ready",  {31'b0, in_ready},  32'd0);
         checkOutput("hold out_valid", {31'b0, out_valid}, 32'd1);
      end
      a_in      = 32'h00000010;
      b_in      = 32'h00000020;
      c_in      = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("release out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("release in_ready",  {31'b0, in_ready},  32'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("next accept in_ready", {31'b0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("next op latency", lat, 32'd4);
      checkOutput("next op sum",     sum, 32'h00000031);
      checkOutput("next op c_out",   {31'b0, c_out}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset while the third slice is about to be added.
      a_in     = 32'h01020304;
      b_in     = 32'h05060708;
      c_in     = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrun rst in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("midrun rst out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrun rst sum",       sum,                32'd0);
      checkOutput("midrun rst c_out",     {31'b0, c_out},     32'd0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (out_valid) seen++;
      end
      checkOutput("midrun rst no out_valid", seen, 32'd0);

      for (int r = 0; r < 20; r++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         {ec, es} = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
         eo = (ra[31] == rb[31]) && (es[31] != ra[31]);
         out_ready = 1'b0;
         applyStimulus(ra, rb, rc, 1'b1, lat);
         checkOutput("rand latency",  lat, 32'd4);
         checkOutput("rand sum",      sum, es);
         checkOutput("rand c_out",    {31'b0, c_out},    {31'b0, ec});
         checkOutput("rand overflow", {31'b0, overflow}, {31'b0, eo});
         g = 0;
         while (g < 30) begin
            if (out_ready) begin
               tick();
               break;
            end
            out_ready = (g >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!out_ready) tick();
            g++;
         end
         out_ready = 1'b0;
         checkOutput("rand out_valid drop", {31'b0, out_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
